// File: rtl/clock_time_counter.sv
`timescale 1ns/1ps
// ============================================================================
// clock_time_counter
//
// BCD hours/minutes/seconds time-of-day counter for the digital clock.
// It advances 00:00:00 -> 23:59:59 -> 00:00:00 on each tick_en pulse while
// run is high. It also supports a synchronous time load and an optional alarm
// comparator.
//
// Optional feature macro: CLOCK_ALARM_EN
//   defined   : the alarm register and comparator are built, and alarm_hit
//               strobes when a tick lands on alarm_hh:alarm_mm:00 while
//               alarm_on is high.
//   undefined : the alarm inputs are ignored, alarm_hit is tied low, and no
//               alarm flops exist.
//
// Parameters
//   RST_HH/RST_MM/RST_SS : BCD time loaded by reset (must be legal values).
//
// Ports
//   clk_in     in   system clock (same domain as the 1 Hz divider)
//   rst_n      in   asynchronous active-low reset
//   tick_en    in   1 Hz single-cycle enable; may be held high to count
//                   once per cycle
//   run        in   1 = count on ticks, 0 = hold (ticks are dropped)
//   load       in   single-cycle request to load set_hh/set_mm/set_ss
//   set_hh/mm/ss in 8-bit BCD load values {tens, ones}
//   alarm_set  in   latch alarm_hh/alarm_mm (invalid BCD silently ignored)
//   alarm_hh/mm in  8-bit BCD alarm time
//   alarm_on   in   alarm arm switch
//   hh/mm/ss   out  registered BCD time
//   min_pulse  out  1 cycle, coincides with the update where ss wraps 59->00
//   day_pulse  out  1 cycle, coincides with the update 23:59:59->00:00:00
//   load_err   out  1 cycle, a load was rejected (time unchanged)
//   alarm_hit  out  1 cycle alarm strobe
//
// Interface protocol: there is no valid/ready handshake. load, alarm_set and
// tick_en are fire-and-forget strobes sampled on every rising clk_in edge.
// Their effect is visible on the outputs right after that edge. Per-cycle
// priority is reset > load > (tick_en & run). A load, whether accepted or
// rejected, discards a coincident tick. The dropped tick is not deferred.
// ============================================================================
module clock_time_counter #(
    parameter logic [7:0] RST_HH = 8'h00,
    parameter logic [7:0] RST_MM = 8'h00,
    parameter logic [7:0] RST_SS = 8'h00
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       tick_en,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] set_hh,
    input  logic [7:0] set_mm,
    input  logic [7:0] set_ss,
    input  logic       alarm_set,
    input  logic [7:0] alarm_hh,
    input  logic [7:0] alarm_mm,
    input  logic       alarm_on,
    output logic [7:0] hh,
    output logic [7:0] mm,
    output logic [7:0] ss,
    output logic       min_pulse,
    output logic       day_pulse,
    output logic       load_err,
    output logic       alarm_hit
);

    // ------------------------------------------------------------------------
    // BCD helpers
    // ------------------------------------------------------------------------
    function automatic logic bcd_ok(input logic [7:0] v);
        bcd_ok = (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // When both nibbles are <= 9, a plain binary compare against a BCD
    // constant orders the values correctly.
    function automatic logic sexa_ok(input logic [7:0] v);
        sexa_ok = bcd_ok(v) && (v <= 8'h59);
    endfunction

    function automatic logic hour_ok(input logic [7:0] v);
        hour_ok = bcd_ok(v) && (v <= 8'h23);
    endfunction

    // Increment modulo 60 in BCD: 59 -> 00.
    function automatic logic [7:0] inc_sexa(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        inc_sexa = r;
    endfunction

    // Increment modulo 24 in BCD. The 23 -> 00 rule is checked before the
    // ones-digit rollover, because 09 -> 10 and 19 -> 20 are ordinary carries.
    function automatic logic [7:0] inc_hour(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h23)           r = 8'h00;
        else if (v[3:0] == 4'd9)  r = {v[7:4] + 4'd1, 4'd0};
        else                      r = {v[7:4], v[3:0] + 4'd1};
        inc_hour = r;
    endfunction

    // ------------------------------------------------------------------------
    // Time registers
    // ------------------------------------------------------------------------
    logic [7:0] hh_r, mm_r, ss_r;
    logic       min_pulse_r, day_pulse_r, load_err_r;

    // Combinational next-time with a carry that ripples through all six
    // digits within one increment.
    logic [7:0] ss_next, mm_next, hh_next;
    logic       ss_carry, mm_carry, day_wrap;
    logic       load_valid;
    logic       advance;

    always_comb begin
        ss_next  = inc_sexa(ss_r);
        ss_carry = (ss_r == 8'h59);
        mm_next  = mm_r;
        mm_carry = 1'b0;
        hh_next  = hh_r;
        day_wrap = 1'b0;
        if (ss_carry) begin
            mm_next  = inc_sexa(mm_r);
            mm_carry = (mm_r == 8'h59);
        end
        if (mm_carry) begin
            hh_next  = inc_hour(hh_r);
            day_wrap = (hh_r == 8'h23);
        end
    end

    always_comb begin
        load_valid = hour_ok(set_hh) && sexa_ok(set_mm) && sexa_ok(set_ss);
        // A load (accepted or rejected) swallows a coincident tick.
        advance    = tick_en && run && !load;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            hh_r        <= RST_HH;
            mm_r        <= RST_MM;
            ss_r        <= RST_SS;
            min_pulse_r <= 1'b0;
            day_pulse_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            min_pulse_r <= 1'b0;
            day_pulse_r <= 1'b0;
            load_err_r  <= 1'b0;
            if (load) begin
                if (load_valid) begin
                    hh_r <= set_hh;
                    mm_r <= set_mm;
                    ss_r <= set_ss;
                end else begin
                    load_err_r <= 1'b1;
                end
            end else if (advance) begin
                hh_r        <= hh_next;
                mm_r        <= mm_next;
                ss_r        <= ss_next;
                // Registered with the time so the pulse coincides with the
                // newly displayed value.
                min_pulse_r <= ss_carry;
                day_pulse_r <= day_wrap;
            end
        end
    end

    assign hh        = hh_r;
    assign mm        = mm_r;
    assign ss        = ss_r;
    assign min_pulse = min_pulse_r;
    assign day_pulse = day_pulse_r;
    assign load_err  = load_err_r;

    // ------------------------------------------------------------------------
    // Optional alarm
    // ------------------------------------------------------------------------
`ifdef CLOCK_ALARM_EN
    logic [7:0] alarm_hh_r, alarm_mm_r;
    logic       alarm_hit_r;
    logic       alarm_match;

    // Only a tick can fire the alarm. A load that lands on the alarm time
    // does not fire it, because advance is low whenever load is high.
    always_comb begin
        alarm_match = advance && alarm_on &&
                      (hh_next == alarm_hh_r) &&
                      (mm_next == alarm_mm_r) &&
                      (ss_next == 8'h00);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hh_r  <= 8'h00;
            alarm_mm_r  <= 8'h00;
            alarm_hit_r <= 1'b0;
        end else begin
            alarm_hit_r <= alarm_match;
            if (alarm_set && hour_ok(alarm_hh) && sexa_ok(alarm_mm)) begin
                alarm_hh_r <= alarm_hh;
                alarm_mm_r <= alarm_mm;
            end
        end
    end

    assign alarm_hit = alarm_hit_r;
`else
    // The alarm inputs stay on the port list but do nothing in this build.
    logic unused_alarm;
    assign unused_alarm = ^{alarm_set, alarm_hh, alarm_mm, alarm_on};
    assign alarm_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_clock_time_counter.sv
`timescale 1ns/1ps
// Directed test for clock_time_counter. Every driven cycle that is checked
// pushes a hand-computed expected output word into exp_q right after the
// clock edge. An independent monitor pops the word on the following falling
// edge and compares it with the DUT outputs.
module tb_clock_time_counter;

`ifdef CLOCK_ALARM_EN
    localparam logic ALARM = 1'b1;
`else
    localparam logic ALARM = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       tick_en, run, load, alarm_set, alarm_on;
    logic [7:0] set_hh, set_mm, set_ss, alarm_hh, alarm_mm;
    logic [7:0] hh, mm, ss;
    logic       min_pulse, day_pulse, load_err, alarm_hit;

    int n_checks = 0;
    int n_fail   = 0;

    // {hh, mm, ss, min_pulse, day_pulse, load_err, alarm_hit}
    logic [27:0] exp_q[$];
    string       name_q[$];

    clock_time_counter dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .tick_en   (tick_en),
        .run       (run),
        .load      (load),
        .set_hh    (set_hh),
        .set_mm    (set_mm),
        .set_ss    (set_ss),
        .alarm_set (alarm_set),
        .alarm_hh  (alarm_hh),
        .alarm_mm  (alarm_mm),
        .alarm_on  (alarm_on),
        .hh        (hh),
        .mm        (mm),
        .ss        (ss),
        .min_pulse (min_pulse),
        .day_pulse (day_pulse),
        .load_err  (load_err),
        .alarm_hit (alarm_hit)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [27:0] ev(input logic [7:0] h, input logic [7:0] m,
                                       input logic [7:0] s, input logic mp,
                                       input logic dp, input logic er,
                                       input logic ah);
        ev = {h, m, s, mp, dp, er, ah};
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        to_bcd = {t, o};
    endfunction

    function automatic logic [27:0] got_word();
        got_word = {hh, mm, ss, min_pulse, day_pulse, load_err, alarm_hit};
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk_in) begin
        logic [27:0] e, g;
        string       nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = got_word();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got %h:%h:%h min=%b day=%b err=%b hit=%b, expected %h:%h:%h min=%b day=%b err=%b hit=%b",
                         nm, g[27:20], g[19:12], g[11:4], g[3], g[2], g[1], g[0],
                         e[27:20], e[19:12], e[11:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic check_now(input logic [27:0] e, input string nm);
        logic [27:0] g;
        g = got_word();
        n_checks++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, g, e);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic chk, input logic [27:0] e, input string nm);
        @(posedge clk_in);
        if (chk) begin
            exp_q.push_back(e);
            name_q.push_back(nm);
        end
        #1;
        tick_en   = 1'b0;
        load      = 1'b0;
        alarm_set = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                           input logic tk, input logic [27:0] e, input string nm);
        set_hh  = h;
        set_mm  = m;
        set_ss  = s;
        load    = 1'b1;
        tick_en = tk;
        cyc(1'b1, e, nm);
    endtask

    task automatic do_tick(input logic [27:0] e, input string nm);
        tick_en = 1'b1;
        cyc(1'b1, e, nm);
    endtask

    task automatic do_alarm_set(input logic [7:0] h, input logic [7:0] m,
                                input logic [27:0] e, input string nm);
        alarm_hh  = h;
        alarm_mm  = m;
        alarm_set = 1'b1;
        cyc(1'b1, e, nm);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0; tick_en = 1'b0; run = 1'b0; load = 1'b0;
        alarm_set = 1'b0; alarm_on = 1'b0;
        set_hh = 8'h00; set_mm = 8'h00; set_ss = 8'h00;
        alarm_hh = 8'h00; alarm_mm = 8'h00;

        #1;
        check_now(ev(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "reset_state");
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        run   = 1'b1;

        // 61 back-to-back ticks from 00:00:00. The single min_pulse lands on
        // tick 60 (ss 59 -> 00).
        for (int i = 0; i < 61; i++) begin
            do_tick(ev(8'h00, to_bcd((i + 1) / 60), to_bcd((i + 1) % 60),
                       (i == 59), 0, 0, 0), "count61");
        end

        // Day wrap
        do_load(8'h23, 8'h59, 8'h58, 0, ev(8'h23, 8'h59, 8'h58, 0, 0, 0, 0), "load_235958");
        do_tick(ev(8'h23, 8'h59, 8'h59, 0, 0, 0, 0), "tick_235959");
        do_tick(ev(8'h00, 8'h00, 8'h00, 1, 1, 0, 0), "day_wrap");
        cyc(1'b1, ev(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "after_wrap_idle");

        // Hour carry 09 -> 10
        do_load(8'h09, 8'h59, 8'h59, 0, ev(8'h09, 8'h59, 8'h59, 0, 0, 0, 0), "load_095959");
        do_tick(ev(8'h10, 8'h00, 8'h00, 1, 0, 0, 0), "hour_carry");

        // Rejected loads leave the time unchanged
        do_load(8'h24, 8'h00, 8'h00, 0, ev(8'h10, 8'h00, 8'h00, 0, 0, 1, 0), "bad_hour");
        do_load(8'h12, 8'h5A, 8'h00, 0, ev(8'h10, 8'h00, 8'h00, 0, 0, 1, 0), "bad_min_nibble");
        do_load(8'h1A, 8'h00, 8'h00, 1, ev(8'h10, 8'h00, 8'h00, 0, 0, 1, 0), "bad_hour_nibble_tick");
        do_load(8'h05, 8'h00, 8'h60, 0, ev(8'h10, 8'h00, 8'h00, 0, 0, 1, 0), "bad_sec");
        cyc(1'b1, ev(8'h10, 8'h00, 8'h00, 0, 0, 0, 0), "err_clears");

        // A load beats a coincident tick, then hold mode drops ticks
        do_load(8'h10, 8'h20, 8'h30, 1, ev(8'h10, 8'h20, 8'h30, 0, 0, 0, 0), "load_with_tick");
        run = 1'b0;
        for (int i = 0; i < 5; i++)
            do_tick(ev(8'h10, 8'h20, 8'h30, 0, 0, 0, 0), "hold_tick");
        do_load(8'h11, 8'h11, 8'h11, 0, ev(8'h11, 8'h11, 8'h11, 0, 0, 0, 0), "load_while_hold");
        run = 1'b1;
        do_tick(ev(8'h11, 8'h11, 8'h12, 0, 0, 0, 0), "resume_tick");

        // Asynchronous reset mid-count
        do_load(8'h07, 8'h45, 8'h11, 0, ev(8'h07, 8'h45, 8'h11, 0, 0, 0, 0), "load_074511");
        do_tick(ev(8'h07, 8'h45, 8'h12, 0, 0, 0, 0), "tick_074512");
        @(negedge clk_in);
        #2;
        rst_n = 1'b0;
        #1;
        check_now(ev(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "async_reset");
        @(posedge clk_in); #1;
        rst_n = 1'b1;

        // Alarm (expected hit follows the build)
        do_alarm_set(8'h06, 8'h30, ev(8'h00, 8'h00, 8'h00, 0, 0, 0, 0), "alarm_set");
        alarm_on = 1'b1;
        do_load(8'h06, 8'h29, 8'h59, 0, ev(8'h06, 8'h29, 8'h59, 0, 0, 0, 0), "load_062959");
        do_tick(ev(8'h06, 8'h30, 8'h00, 1, 0, 0, ALARM), "alarm_fire");
        cyc(1'b1, ev(8'h06, 8'h30, 8'h00, 0, 0, 0, 0), "alarm_one_cycle");
        do_load(8'h06, 8'h30, 8'h00, 0, ev(8'h06, 8'h30, 8'h00, 0, 0, 0, 0), "load_on_alarm");
        alarm_on = 1'b0;
        do_load(8'h06, 8'h29, 8'h59, 0, ev(8'h06, 8'h29, 8'h59, 0, 0, 0, 0), "reload_062959");
        do_tick(ev(8'h06, 8'h30, 8'h00, 1, 0, 0, 0), "alarm_disarmed");
        do_alarm_set(8'h24, 8'h00, ev(8'h06, 8'h30, 8'h00, 0, 0, 0, 0), "alarm_set_bad");
        alarm_on = 1'b1;
        do_load(8'h06, 8'h29, 8'h59, 0, ev(8'h06, 8'h29, 8'h59, 0, 0, 0, 0), "reload2_062959");
        do_tick(ev(8'h06, 8'h30, 8'h00, 1, 0, 0, ALARM), "alarm_kept");

        // Drain the scoreboard
        @(negedge clk_in);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_time_counter.md
# clock_time_counter

BCD hours/minutes/seconds time-of-day counter for the digital clock. Sits directly downstream of the 1 Hz divider and consumes its single-cycle `clk_1hz_en` pulse as `tick_en`, advancing 00:00:00 → 23:59:59 → 00:00:00. Supports synchronous time loading and run/hold, and provides registered BCD digits to the display path. An optional alarm comparator is compiled in by macro.

## Interface
Parameters:
- `RST_HH`, 8'h00, BCD hour loaded on reset; must be a legal BCD hour 00–23.
- `RST_MM`, 8'h00, BCD minute loaded on reset; must be 00–59.
- `RST_SS`, 8'h00, BCD second loaded on reset; must be 00–59.

Ports:
- `clk_in` in 1: system clock, the same 50 MHz domain as the divider.
- `rst_n` in 1: asynchronous, active-low reset.
- `tick_en` in 1: 1 Hz single-cycle enable from the divider.
- `run` in 1: 1 = count on ticks; 0 = hold the current time.
- `load` in 1: single-cycle request to load `set_hh`/`set_mm`/`set_ss`.
- `set_hh`, `set_mm`, `set_ss` in 8 each: BCD load values as {tens, ones}.
- `alarm_set` in 1: latch `alarm_hh`/`alarm_mm` into the alarm register.
- `alarm_hh`, `alarm_mm` in 8 each: BCD alarm time.
- `alarm_on` in 1: alarm arm switch.
- `hh`, `mm`, `ss` out 8 each: registered BCD time.
- `min_pulse` out 1: one cycle wide; asserted on the cycle after ss wraps 59→00.
- `day_pulse` out 1: one cycle wide; asserted on the cycle after 23:59:59→00:00:00.
- `load_err` out 1: one cycle wide; asserted when a load was rejected.
- `alarm_hit` out 1: one cycle wide alarm strobe.

## Operation
- Six BCD digit registers. Ones digits count 0–9. Tens limits: seconds and minutes 0–5; hours follow the 23→00 rule.
- A carry ripples combinationally within a single increment. Every output is updated from registers only.
- Priority per cycle: reset > `load` > (`tick_en` & `run`).
- `load` with valid values: digits take the set values, and any coincident tick is discarded (not deferred).
- `load` validity rules:
  - Every nibble must be ≤9.
  - `set_hh` must be ≤8'h23.
  - `set_mm` and `set_ss` must be ≤8'h59.
- `load` with any invalid field: the time is left unchanged, `load_err` = 1 for one cycle, and a coincident tick is still discarded.
- `run` = 0: ticks are ignored and not accumulated. Loads remain accepted.
- `tick_en` held high for multiple cycles increments once per cycle. This is legal and is used by test benches.
- `min_pulse`/`day_pulse` are registered with the time update, so they coincide with the new displayed value. A load never generates them.
- Alarm:
  - The alarm register (reset 00:00) latches on `alarm_set`; invalid BCD is rejected silently.
  - `alarm_hit` = 1 for one cycle when a tick causes the time to become alarm_hh:alarm_mm:00 while `alarm_on` = 1.
  - A load landing on the alarm time does not fire the alarm.

## Timing
- Reset values: `hh`/`mm`/`ss` = `RST_HH`/`RST_MM`/`RST_SS`; the alarm register = 00:00; all pulse outputs = 0.
- Latency: a tick or load sampled at edge N becomes visible on the outputs after edge N, i.e. one cycle.
- `rst_n` assertion mid-count clears immediately (asynchronous). Release is assumed synchronous to `clk_in`.
- No handshakes: `load` and `alarm_set` are fire-and-forget and accepted in any cycle.

## Configuration
- `CLOCK_ALARM_EN` defined:
  - The alarm register and comparator are built.
  - `alarm_hit` behaves as described under Operation.
- `CLOCK_ALARM_EN` undefined:
  - The alarm ports remain on the module.
  - The alarm inputs are ignored.
  - `alarm_hit` is tied to 0.
  - No alarm flops are synthesized.

## Test plan
- Reset with defaults, then 61 ticks at `run` = 1 → `ss` = 8'h01, `mm` = 8'h01, and exactly one `min_pulse` (on the ss 59→00 update).
- Load 23:59:58, then 2 ticks → 23:59:59, then 00:00:00. `day_pulse` and `min_pulse` both = 1 on the wrap cycle.
- Load 8'h24:00:00 and then 12:5A:00 → `load_err` pulses each time, and the time is unchanged.
- `load` 10:20:30 and `tick_en` in the same cycle → output is 10:20:30 with no increment. Then `run` = 0 with 5 ticks → still 10:20:30.
- Assert `rst_n` = 0 mid-count at 07:45:12 → outputs go to the reset values before the next clock edge.
- With `CLOCK_ALARM_EN` defined: alarm set to 06:30, `alarm_on` = 1, load 06:29:59, 1 tick → `alarm_hit` one cycle. Repeat with `alarm_on` = 0 → no pulse. Without the macro → `alarm_hit` stays 0.
